// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. It produces {remainder, quotient} 33 cycles after the request.
// Define DIV_ZERO_FAST_EN to short-cut a zero divisor through BYZERO with a zero result.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // BUSY   | 32 shift/subtract iterations, r_cnt counts them
  // DONE   | result presented, ready_o high until start_i drops
  // BYZERO | zero divisor short-cut (DIV_ZERO_FAST_EN only)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
`ifdef DIV_ZERO_FAST_EN
    S_BYZERO = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;
  logic        w_last;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_a_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign w_b_abs = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // The partial remainder always stays below the divisor, so 32 bits hold it;
  // only the shifted value needs the extra bit, and only for the compare.
  assign w_shift    = {r_rem, r_quot[31]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_nxt  = w_ge ? (w_shift[31:0] - r_divisor) : w_shift[31:0];
  assign w_quot_nxt = {r_quot[30:0], w_ge};
  assign w_last     = (r_cnt == 5'd31);
  assign w_q_fix    = r_neg_q ? -w_quot_nxt : w_quot_nxt;
  assign w_r_fix    = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  assign ready_o = (r_state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (annul_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            w_next = (opdata2_i == 32'h0) ? S_BYZERO : S_BUSY;
`else
            w_next = S_BUSY;
`endif
          end
        end
        S_BUSY:   if (w_last) w_next = S_DONE;
        S_DONE:   if (!start_i) w_next = S_IDLE;
`ifdef DIV_ZERO_FAST_EN
        S_BYZERO: w_next = S_DONE;
`endif
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= 5'd0;
      r_rem     <= 32'h0;
      r_quot    <= 32'h0;
      r_divisor <= 32'h0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= 64'h0;
    end else if (!annul_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_quot    <= w_a_abs;
            r_divisor <= w_b_abs;
            r_rem     <= 32'h0;
            r_cnt     <= 5'd0;
            r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r   <= signed_div_i & opdata1_i[31];
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt + 5'd1;
          if (w_last) result_o <= {w_r_fix, w_q_fix};
        end
`ifdef DIV_ZERO_FAST_EN
        S_BYZERO: result_o <= 64'h0;
`endif
        default: ;
      endcase
    end
  end

endmodule
